// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-RAM port of the MEM stage.
// The master is the pipeline stage and the slave is the RAM.
interface mem_access_stage_if #(
    parameter int ADDR_W = 8
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ack;

    modport master (
        output ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_be, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: big-endian byte/half/word loads and stores over a req/ack RAM, stalling upstream while busy.
// Optional macro MEM_MISALIGN_CHK_EN traps misaligned accesses and adds the misalign_trap port.
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] MEM_ALU_OUT_in,
    input  logic [31:0] MEM_RB_in,
    input  logic [3:0]  MEM_RAM_CTRL_in,
    input  logic        MEM_L_in,
    input  logic [4:0]  MEM_RD_in,
    input  logic        MEM_RF_LE_in,
    output logic [31:0] MEM_PD_out,
    output logic [4:0]  MEM_RD_out,
    output logic        MEM_RF_LE_out,
    output logic        stall_out,
    output logic        mem_err,
`ifdef MEM_MISALIGN_CHK_EN
    output logic        misalign_trap,
`endif
    mem_access_stage_if.master ram
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_latch;
    logic [1:0]       size_q;
    logic [1:0]       off_q;

    logic       en;
    logic       is_write;
    logic [1:0] size;
    logic [1:0] off;
    logic       trap;

    assign en       = MEM_RAM_CTRL_in[3];
    assign is_write = MEM_RAM_CTRL_in[2];
    assign size     = MEM_RAM_CTRL_in[1:0];
    assign off      = MEM_ALU_OUT_in[1:0];

`ifdef MEM_MISALIGN_CHK_EN
    assign trap = (state == IDLE) && en &&
                  (((size == 2'b01) && off[0]) || (size[1] && (off != 2'b00)));
    assign misalign_trap = trap;
`else
    assign trap = 1'b0;
`endif

    // Lane 0 is bits [31:24]; half ignores off[0] and word ignores off, so accesses are forced aligned.
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
        case (sz)
            2'b00:   lane_be = 4'b1000 >> o;
            2'b01:   lane_be = o[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] rb);
        case (sz)
            2'b00:   lane_wdata = {4{rb[7:0]}};
            2'b01:   lane_wdata = {2{rb[15:0]}};
            default: lane_wdata = rb;
        endcase
    endfunction

    function automatic logic [31:0] lane_load(input logic [1:0] sz, input logic [1:0] o,
                                              input logic [31:0] d);
        case (sz)
            2'b00: begin
                case (o)
                    2'd0:    lane_load = {24'h0, d[31:24]};
                    2'd1:    lane_load = {24'h0, d[23:16]};
                    2'd2:    lane_load = {24'h0, d[15:8]};
                    default: lane_load = {24'h0, d[7:0]};
                endcase
            end
            2'b01:   lane_load = o[1] ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
            default: lane_load = d;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        stall_out  = 1'b0;
        MEM_PD_out = MEM_L_in ? 32'h0 : MEM_ALU_OUT_in;
        case (state)
            IDLE:    stall_out = en && !trap;
            REQ:     stall_out = 1'b1;
            DONE:    if (MEM_L_in) MEM_PD_out = rdata_latch;
            default: stall_out = 1'b0;
        endcase
    end

    assign MEM_RF_LE_out = MEM_RF_LE_in & ~stall_out & ~trap;
    assign MEM_RD_out    = MEM_RD_in;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            cnt           <= '0;
            // NOTE: the load-data latch is a plain register and is cleared like all other state.
            rdata_latch   <= '0;
            size_q        <= '0;
            off_q         <= '0;
            mem_err       <= 1'b0;
            ram.ram_req   <= 1'b0;
            ram.ram_we    <= 1'b0;
            ram.ram_addr  <= '0;
            ram.ram_be    <= '0;
            ram.ram_wdata <= '0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && !trap) begin
                        ram.ram_req   <= 1'b1;
                        ram.ram_we    <= is_write;
                        ram.ram_addr  <= MEM_ALU_OUT_in[ADDR_W+1:2];
                        ram.ram_be    <= lane_be(size, off);
                        ram.ram_wdata <= lane_wdata(size, MEM_RB_in);
                        size_q        <= size;
                        off_q         <= off;
                        cnt           <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    // An ack on the last allowed cycle still completes normally.
                    if (ram.ram_ack) begin
                        rdata_latch <= ram.ram_we ? 32'h0 : lane_load(size_q, off_q, ram.ram_rdata);
                        ram.ram_req <= 1'b0;
                        ram.ram_we  <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata_latch <= 32'h0;
                        ram.ram_req <= 1'b0;
                        ram.ram_we  <= 1'b0;
                        mem_err     <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a per-cycle reference model plus literal checks on captured results.
// Honours MEM_MISALIGN_CHK_EN when defined.
module tb_mem_access_stage;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] alu;
    logic [31:0] rb;
    logic [3:0]  ctrl;
    logic        l_sel;
    logic [4:0]  rd;
    logic        rf_le;
    logic [31:0] pd;
    logic [4:0]  rd_out;
    logic        rf_le_out;
    logic        stall;
    logic        mem_err;
`ifdef MEM_MISALIGN_CHK_EN
    logic        trap_out;
`endif

    mem_access_stage_if #(.ADDR_W(ADDR_W)) ram ();

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .Reset           (Reset),
        .MEM_ALU_OUT_in  (alu),
        .MEM_RB_in       (rb),
        .MEM_RAM_CTRL_in (ctrl),
        .MEM_L_in        (l_sel),
        .MEM_RD_in       (rd),
        .MEM_RF_LE_in    (rf_le),
        .MEM_PD_out      (pd),
        .MEM_RD_out      (rd_out),
        .MEM_RF_LE_out   (rf_le_out),
        .stall_out       (stall),
        .mem_err         (mem_err),
`ifdef MEM_MISALIGN_CHK_EN
        .misalign_trap   (trap_out),
`endif
        .ram             (ram)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Values captured from the DUT during one run_op call.
    logic [31:0] cap_stalls, cap_req, cap_addr, cap_be, cap_wdata, cap_we, cap_err, cap_pd, cap_le;
    logic [31:0] cap_trap;

    // Reference model state.
    int          m_phase;  // 0 waiting for an op, 1 access outstanding, 2 retiring
    int          m_reqs;
    logic [31:0] m_addr, m_be, m_wdata, m_we, m_latch, m_err;
    logic [1:0]  m_size, m_off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int first_lane(input logic [1:0] sz, input logic [1:0] o);
        return int'(o) - (int'(o) % nbytes(sz));
    endfunction

    function automatic logic [31:0] exp_be(input logic [1:0] sz, input logic [1:0] o);
        logic [31:0] be = 32'h0;
        int s = first_lane(sz, o);
        for (int k = s; k < s + nbytes(sz); k++) be[3-k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] b = {24'h0, d[7:0]};
        logic [31:0] h = {16'h0, d[15:0]};
        if (nbytes(sz) == 1) return b * 32'h0101_0101;
        if (nbytes(sz) == 2) return h * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [1:0] o,
                                             input logic [31:0] d);
        int          n     = nbytes(sz);
        int          shift = 8 * (4 - first_lane(sz, o) - n);
        logic [63:0] mask  = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] wide  = {32'h0, d} >> shift;
        logic [63:0] res   = wide & mask;
        return res[31:0];
    endfunction

    task automatic model_loop();
        logic [31:0] e_stall, e_pd, e_le, e_trap;
        logic [1:0]  sz, of;
        forever begin
            @(negedge clk);
            if (!Reset) begin
                m_phase = 0; m_reqs = 0; m_err = 0; m_we = 0;
                m_addr = 0; m_be = 0; m_wdata = 0; m_latch = 0;
                check("rst_req",   32'(ram.ram_req),   32'h0);
                check("rst_we",    32'(ram.ram_we),    32'h0);
                check("rst_addr",  32'(ram.ram_addr),  32'h0);
                check("rst_be",    32'(ram.ram_be),    32'h0);
                check("rst_wdata", ram.ram_wdata,      32'h0);
                check("rst_err",   32'(mem_err),       32'h0);
            end else begin
                sz = ctrl[1:0];
                of = alu[1:0];
                e_trap = 0;
`ifdef MEM_MISALIGN_CHK_EN
                if (m_phase == 0 && ctrl[3] && (int'(of) % nbytes(sz)) != 0) e_trap = 1;
`endif
                e_stall = (m_phase == 1 || (m_phase == 0 && ctrl[3] && e_trap == 0)) ? 1 : 0;
                e_pd    = (m_phase == 2 && l_sel) ? m_latch : (l_sel ? 32'h0 : alu);
                e_le    = (rf_le && e_stall == 0 && e_trap == 0) ? 1 : 0;

                check("stall",  32'(stall),       e_stall);
                check("rf_le",  32'(rf_le_out),   e_le);
                check("rd",     32'(rd_out),      32'(rd));
                check("req",    32'(ram.ram_req), (m_phase == 1) ? 32'h1 : 32'h0);
                check("memerr", 32'(mem_err),     m_err);
`ifdef MEM_MISALIGN_CHK_EN
                check("trap",   32'(trap_out),    e_trap);
`endif
                if (e_stall == 0) check("pd", pd, e_pd);
                if (m_phase == 1) begin
                    check("we",    32'(ram.ram_we),   m_we);
                    check("addr",  32'(ram.ram_addr), m_addr);
                    check("be",    32'(ram.ram_be),   m_be);
                    check("wdata", ram.ram_wdata,     m_wdata);
                end

                if (m_phase == 0) begin
                    m_err = 0;
                    if (ctrl[3] && e_trap == 0) begin
                        m_phase = 1; m_reqs = 0;
                        m_addr  = {24'h0, alu[ADDR_W+1:2]};
                        m_be    = exp_be(sz, of);
                        m_wdata = exp_wdata(sz, rb);
                        m_we    = {31'h0, ctrl[2]};
                        m_size  = sz; m_off = of;
                    end
                end else if (m_phase == 1) begin
                    m_reqs++;
                    if (ram.ram_ack) begin
                        m_latch = (m_we != 0) ? 32'h0 : exp_load(m_size, m_off, ram.ram_rdata);
                        m_phase = 2; m_we = 0;
                    end else if (m_reqs == TIMEOUT) begin
                        m_latch = 0; m_err = 1; m_phase = 2; m_we = 0;
                    end
                end else begin
                    m_phase = 0; m_err = 0;
                end
            end
        end
    endtask

    // Called at posedge+1; holds the op for ncyc cycles and acks on REQ cycle ack_on (0 = never).
    task automatic run_op(input logic [3:0] c_in, input logic l_in, input logic [31:0] a_in,
                          input logic [31:0] b_in, input logic [4:0] d_in, input logic le_in,
                          input int ack_on, input logic [31:0] rdat, input int ncyc);
        ctrl = c_in; l_sel = l_in; alu = a_in; rb = b_in; rd = d_in; rf_le = le_in;
        ram.ram_rdata = rdat;
        cap_stalls = 0; cap_req = 0; cap_addr = 0; cap_be = 0; cap_wdata = 0;
        cap_we = 0; cap_err = 0; cap_pd = 0; cap_le = 0; cap_trap = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            ram.ram_ack = (ack_on > 0) && (cyc == ack_on);
            #3;
            if (stall) cap_stalls = cap_stalls + 1;
            if (ram.ram_req) begin
                cap_req = 1; cap_addr = 32'(ram.ram_addr); cap_be = 32'(ram.ram_be);
                cap_wdata = ram.ram_wdata; cap_we = 32'(ram.ram_we);
            end
            if (mem_err) cap_err = 1;
`ifdef MEM_MISALIGN_CHK_EN
            if (trap_out) cap_trap = 1;
`endif
            cap_pd = pd;
            cap_le = 32'(rf_le_out);
            @(posedge clk);
            #1;
        end
        ram.ram_ack = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        alu = 0; rb = 0; ctrl = 0; l_sel = 0; rd = 0; rf_le = 0;
        ram.ram_ack = 1'b0; ram.ram_rdata = 32'h0;
        fork
            model_loop();
        join_none

        #2;
        check("init_req",   32'(ram.ram_req), 32'h0);
        check("init_stall", 32'(stall),       32'h0);
        check("init_err",   32'(mem_err),     32'h0);
        @(posedge clk); @(posedge clk); #2;
        Reset = 1'b1;
        @(posedge clk); #1;

        // Non-memory op passes ALU_OUT straight through.
        run_op(4'b0000, 1'b0, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 0, 32'h0, 1);
        check("nm_pd", cap_pd, 32'h1234_5678);
        check("nm_le", cap_le, 32'h1);
        check("nm_stall", cap_stalls, 32'h0);
        check("nm_req", cap_req, 32'h0);

        // Word load at 0x10, ack on third REQ cycle.
        run_op(4'b1010, 1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 3, 32'hDEAD_BEEF, 5);
        check("wl_stalls", cap_stalls, 32'd4);
        check("wl_addr", cap_addr, 32'h4);
        check("wl_be", cap_be, 32'hF);
        check("wl_pd", cap_pd, 32'hDEAD_BEEF);
        check("wl_le", cap_le, 32'h1);

        run_op(4'b1000, 1'b1, 32'h13, 32'h0, 5'd6, 1'b1, 1, 32'hAABB_CCDD, 3);
        check("bl_be", cap_be, 32'h1);
        check("bl_pd", cap_pd, 32'h0000_00DD);
        run_op(4'b1001, 1'b1, 32'h02, 32'h0, 5'd7, 1'b1, 2, 32'hAABB_CCDD, 4);
        check("hl_be", cap_be, 32'h3);
        check("hl_pd", cap_pd, 32'h0000_CCDD);

        // Byte store with register write disabled; PD in DONE is ALU_OUT since L=0.
        run_op(4'b1100, 1'b0, 32'h11, 32'h0000_0077, 5'd8, 1'b0, 1, 32'h0, 3);
        check("bs_we", cap_we, 32'h1);
        check("bs_be", cap_be, 32'h4);
        check("bs_wdata", cap_wdata, 32'h7777_7777);
        check("bs_le", cap_le, 32'h0);
        check("bs_pd", cap_pd, 32'h11);

        run_op(4'b1101, 1'b0, 32'h02, 32'hFFFF_ABCD, 5'd9, 1'b0, 1, 32'h0, 3);
        check("hs_be", cap_be, 32'h3);
        check("hs_wdata", cap_wdata, 32'hABCD_ABCD);

        // Timeout with no ack, then ack coinciding with the last allowed cycle.
        run_op(4'b1010, 1'b1, 32'h20, 32'h0, 5'd10, 1'b1, 0, 32'h5555_5555, TIMEOUT + 2);
        check("to_err", cap_err, 32'h1);
        check("to_pd", cap_pd, 32'h0);
        check("to_stalls", cap_stalls, 32'(TIMEOUT + 1));
        run_op(4'b1010, 1'b1, 32'h20, 32'h0, 5'd11, 1'b1, TIMEOUT, 32'h0102_0304, TIMEOUT + 2);
        check("co_err", cap_err, 32'h0);
        check("co_pd", cap_pd, 32'h0102_0304);

        // Reserved size behaves as word; non-memory load selects zero.
        run_op(4'b1011, 1'b1, 32'h24, 32'h0, 5'd12, 1'b1, 1, 32'hCAFE_F00D, 3);
        check("rs_be", cap_be, 32'hF);
        check("rs_addr", cap_addr, 32'h9);
        check("rs_pd", cap_pd, 32'hCAFE_F00D);
        run_op(4'b0000, 1'b1, 32'h55, 32'h0, 5'd13, 1'b1, 0, 32'h0, 1);
        check("nl_pd", cap_pd, 32'h0);

`ifdef MEM_MISALIGN_CHK_EN
        run_op(4'b1010, 1'b1, 32'h12, 32'h0, 5'd14, 1'b1, 0, 32'h1122_3344, 1);
        check("mw_trap", cap_trap, 32'h1);
        check("mw_req", cap_req, 32'h0);
        check("mw_le", cap_le, 32'h0);
        check("mw_stall", cap_stalls, 32'h0);
        run_op(4'b1001, 1'b1, 32'h03, 32'h0, 5'd15, 1'b1, 0, 32'h1122_3344, 1);
        check("mh_trap", cap_trap, 32'h1);
`else
        run_op(4'b1010, 1'b1, 32'h12, 32'h0, 5'd14, 1'b1, 1, 32'h1122_3344, 3);
        check("uw_addr", cap_addr, 32'h4);
        check("uw_be", cap_be, 32'hF);
        check("uw_pd", cap_pd, 32'h1122_3344);
        run_op(4'b1001, 1'b1, 32'h03, 32'h0, 5'd15, 1'b1, 1, 32'h1122_3344, 3);
        check("uh_be", cap_be, 32'h3);
        check("uh_pd", cap_pd, 32'h0000_3344);
`endif

        // Reset during an outstanding request drops req at once.
        ctrl = 4'b1010; l_sel = 1'b1; alu = 32'h40; rd = 5'd16; rf_le = 1'b1;
        ram.ram_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req_before", 32'(ram.ram_req), 32'h1);
        #1 Reset = 1'b0;
        #1 check("mid_req_after", 32'(ram.ram_req), 32'h0);
        ctrl = 4'b0000;
        @(posedge clk); #2;
        Reset = 1'b1;
        #2 check("mid_idle_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        run_op(4'b1000, 1'b1, 32'h13, 32'h0, 5'd17, 1'b1, 1, 32'hAABB_CCDD, 3);
        check("post_rst_pd", cap_pd, 32'h0000_00DD);
        check("post_rst_stalls", cap_stalls, 32'd2);

        run_op(4'b0000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 0, 32'h0, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
